io_interrupt_controller: RTL and testbench
==========================================

# io_interrupt_controller

Collects up to eight external interrupt lines, latches them as pending, applies a software mask, and presents one prioritized request to the CPU on `io_interrupt`. It sits on the CPU's IO side, directly upstream of the control unit's interrupt entry. It serves the control unit's interrupt strobes `io_store_retaddr`, `io_push_retaddr`, `io_push_ints` and `io_push_int_addr` over the shared `d_bus`. It owns the return-address storage used for interrupt entry and exit.

## Interface
- VECTOR_BASE, 16'hFF00, vector address of source 0
- VECTOR_STRIDE, 16'h0004, vector spacing per source
- MASK_ADDR, 16'hFFF0, `d_addr` value selecting the mask register for `io_read`/`io_write`
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- irq_in  in  8  raw interrupt lines, asynchronous, rising-edge triggered
- io_interrupt  out  1  registered request to CPU
- io_store_retaddr  in  1  capture `d_bus` as return address; acknowledges the current request
- io_push_retaddr  in  1  drive the saved return address onto `d_bus`; end-of-interrupt
- io_push_ints  in  1  drive {in_service[7:0], pending[7:0]} onto `d_bus`
- io_push_int_addr  in  1  drive the vector of the active source onto `d_bus`
- io_read, io_write  in  1  mask register access, qualified by `d_addr == MASK_ADDR`
- d_addr  in  16  data address bus
- d_bus  inout  16  shared data bus; driven only while a push strobe or a qualified `io_read` is high, else Z

## Operation
- Each `irq_in` bit passes through a 2-flop synchronizer and a rising-edge detector. A detected edge sets `pending[i]`.
- `mask` bit set = source enabled. Reset value of `mask` is 8'h00.
- Candidate: the lowest index i with `pending[i] & mask[i]`. Index 0 has the highest priority.
- States:
  - IDLE → REQ when a candidate exists and is not blocked.
  - REQ → SERVICE on `io_store_retaddr`. `io_interrupt` stays high for the whole of REQ.
  - SERVICE → IDLE on `io_push_retaddr` when the stack becomes empty.
  - SERVICE → REQ on an unblocked preempting candidate.
- Acknowledge on `io_store_retaddr` in REQ:
  - Pushes `d_bus` onto the return stack.
  - Pushes the source index onto the source stack.
  - Clears `pending[src]` and sets `in_service[src]`.
- `io_store_retaddr` outside REQ is ignored.
- `io_push_int_addr` drives VECTOR_BASE + src×VECTOR_STRIDE for the top-of-stack source. Arithmetic is modulo 2^16.
- `io_push_retaddr` drives the top return address, pops it, and clears `in_service` of the popped source. On an empty stack it drives 16'h0000 and changes no state.
- Blocked means:
  - some `in_service` bit is at or above the candidate's priority, or
  - the stack is full.
- A new edge and an acknowledge-clear on the same bit in the same cycle: set wins.
- Several `d_bus` drive strobes high at once is illegal. The priority is `io_push_retaddr` > `io_push_int_addr` > `io_push_ints` > `io_read`.
- `io_write` to MASK_ADDR loads `mask` from `d_bus[7:0]`. Masking does not clear `pending`.

## Timing
- Reset values: `io_interrupt`=0, `pending`=0, `in_service`=0, `mask`=0, stack empty, state IDLE, `d_bus` Z.
- `rst_n` low mid-service discards the stack immediately.
- `irq_in` rising edge → `pending` set 3 cycles later.
- `io_interrupt` rises on the cycle after the candidate is valid and unblocked.
- `io_interrupt` falls on the cycle after `io_store_retaddr`.
- Strobes are single-cycle. Bus drives are combinational from the strobes, in the same cycle.
- Stack and mask updates occur at the closing edge of the strobe cycle.

## Configuration
- INTC_NESTING_EN defined: 4-deep return/source stack. A higher-priority source preempts SERVICE.
- INTC_NESTING_EN undefined: depth 1. Any nonzero `in_service` blocks all requests.

## Structure
- `intc_pkg` holds:
  - state enum (IDLE, REQ, SERVICE)
  - `NUM_SRC`=8
  - stack depth constant selected by INTC_NESTING_EN
- Sub-module `irq_sync_edge` contains the per-line synchronizer and edge detector, instantiated 8×.

## Test plan
- Reset, then pulse `irq_in[3]` with `mask`=0 → `pending`=8'h08, `io_interrupt` stays 0. Then write `mask`=8'h08 → `io_interrupt`=1 on the next cycle.
- Simultaneous edges on 2 and 5, both enabled → `io_push_int_addr` drives 16'hFF08. After EOI, source 5 is served with vector 16'hFF14.
- `io_store_retaddr` with `d_bus`=16'h1234, then `io_push_retaddr` → `d_bus`=16'h1234 and `in_service` returns to 0.
- With nesting: serve source 4, then edge on source 1 → preempt. `io_push_ints` reads 16'h1200 during source 1 service.
- Without nesting: the same stimulus leaves `io_interrupt`=0 until EOI of source 4.
- Assert `rst_n` low while in SERVICE → all state is cleared asynchronously. `io_push_retaddr` then drives 16'h0000.

Source files
------------

// File: rtl/io_interrupt_controller_pkg.sv
// Shared types and constants for io_interrupt_controller.
// Build option: define INTC_NESTING_EN for a 4-deep nesting stack.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } state_t;

   localparam int NUM_SRC = 8;

`ifdef INTC_NESTING_EN
   localparam int STACK_DEPTH = 4;
`else
   localparam int STACK_DEPTH = 1;
`endif

   localparam logic [15:0] VECTOR_BASE   = 16'hFF00;
   localparam logic [15:0] VECTOR_STRIDE = 16'h0004;
   localparam logic [15:0] MASK_ADDR     = 16'hFFF0;

   // Vector address of a source, wrapping modulo 2^16.
   function automatic logic [15:0] vec_addr(input logic [2:0] src);
      return VECTOR_BASE + ({13'd0, src} * VECTOR_STRIDE);
   endfunction

endpackage

// File: rtl/io_interrupt_controller_if.sv
// Interrupt lines plus CPU-side strobes of io_interrupt_controller.
// The shared d_bus stays a plain inout port on the controller.
interface io_interrupt_controller_if;

   logic [7:0]  irq_in;
   logic        io_interrupt;
   logic        io_store_retaddr;
   logic        io_push_retaddr;
   logic        io_push_ints;
   logic        io_push_int_addr;
   logic        io_read;
   logic        io_write;
   logic [15:0] d_addr;

   modport master (
      output irq_in, io_store_retaddr, io_push_retaddr,
      output io_push_ints, io_push_int_addr,
      output io_read, io_write, d_addr,
      input  io_interrupt
   );

   modport slave (
      input  irq_in, io_store_retaddr, io_push_retaddr,
      input  io_push_ints, io_push_int_addr,
      input  io_read, io_write, d_addr,
      output io_interrupt
   );

endinterface

// File: rtl/io_interrupt_controller_irq_sync_edge.sv
// Per-line 2-flop synchronizer and rising-edge detector.
// rise pulses for one cycle, two clocks after the line is first sampled high.
module irq_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise
);

   logic s1, s2, prev;

   // Synchronize the raw line and keep one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= irq;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise = s2 & ~prev;

endmodule

// File: rtl/io_interrupt_controller.sv
// Eight-line prioritized interrupt controller with return-address stack.
// Build option: INTC_NESTING_EN enables preemption and a 4-deep stack.
module io_interrupt_controller
   import intc_pkg::*;
(
   input logic clk,
   input logic rst_n,
   io_interrupt_controller_if.slave bus,
   inout wire [15:0] d_bus
);

   state_t      state, state_nxt;
   logic [7:0]  pending, in_service, mask;
   logic [7:0]  rise, active, clr;
   logic [15:0] ret_stk [4];
   logic [2:0]  src_stk [4];
   logic [2:0]  sp;
   logic [1:0]  top;
   logic [2:0]  cand;
   logic        cand_valid, full, blocked, req_ok;
   logic        ack, pop, mask_sel;
   logic        drv_en;
   logic [15:0] drv_val;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .irq  (bus.irq_in[g]),
         .rise (rise[g])
      );
   end

   assign active   = pending & mask;
   assign top      = 2'(sp - 3'd1);
   assign full     = (sp == 3'(STACK_DEPTH));
   assign mask_sel = (bus.d_addr == MASK_ADDR);
   assign ack      = bus.io_store_retaddr & (state == REQ);
   assign pop      = bus.io_push_retaddr & (sp != 3'd0);
   assign clr      = ack ? (8'd1 << cand) : 8'd0;

   // Lowest-index enabled pending source is the candidate.
   always_comb begin
      cand_valid = 1'b0;
      cand       = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            cand_valid = 1'b1;
            cand       = 3'(i);
         end
      end
   end

`ifdef INTC_NESTING_EN
   logic [7:0] upto;
   assign upto    = 8'hFF >> (3'd7 - cand);
   assign blocked = (|(in_service & upto)) | full;
`else
   assign blocked = (|in_service) | full;
`endif

   assign req_ok = cand_valid & ~blocked;

   // Next-state: a fresh unblocked candidate wins over retiring to IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_ok) state_nxt = REQ;
         REQ:     if (ack) state_nxt = SERVICE;
         SERVICE: begin
            if (req_ok)
               state_nxt = REQ;
            else if (pop && sp == 3'd1)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Pending, in-service and return/source stack bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= 8'h00;
         in_service <= 8'h00;
         sp         <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            ret_stk[i] <= 16'h0000;
            src_stk[i] <= 3'd0;
         end
      end else begin
         pending <= (pending & ~clr) | rise;
         if (ack) begin
            ret_stk[sp[1:0]]  <= d_bus;
            src_stk[sp[1:0]]  <= cand;
            in_service[cand]  <= 1'b1;
            sp                <= sp + 3'd1;
         end else if (pop) begin
            in_service[src_stk[top]] <= 1'b0;
            sp                       <= sp - 3'd1;
         end
      end
   end

   // Software mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mask <= 8'h00;
      else if (bus.io_write && mask_sel)
         mask <= d_bus[7:0];
   end

   // Bus drive mux; retaddr > int_addr > ints > mask read.
   always_comb begin
      drv_en  = 1'b1;
      drv_val = 16'h0000;
      if (bus.io_push_retaddr)
         drv_val = (sp != 3'd0) ? ret_stk[top] : 16'h0000;
      else if (bus.io_push_int_addr)
         drv_val = (sp != 3'd0) ? vec_addr(src_stk[top]) : 16'h0000;
      else if (bus.io_push_ints)
         drv_val = {in_service, pending};
      else if (bus.io_read && mask_sel)
         drv_val = {8'h00, mask};
      else
         drv_en = 1'b0;
   end

   assign d_bus = drv_en ? drv_val : 16'hzzzz;
   assign bus.io_interrupt = (state == REQ);

endmodule

// File: tb/tb_io_interrupt_controller.sv
// Self-checking bench for io_interrupt_controller.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_io_interrupt_controller;

   localparam int DEPTH = intc_pkg::STACK_DEPTH;
`ifdef INTC_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif
   localparam logic [15:0] MADDR = 16'hFFF0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   wire [15:0] d_bus;
   logic tb_drv_en = 1'b0;
   logic [15:0] tb_drv_val = 16'h0000;

   int checks = 0;
   int failures = 0;

   io_interrupt_controller_if bus_if ();

   io_interrupt_controller dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if),
      .d_bus(d_bus)
   );

   assign d_bus = tb_drv_en ? tb_drv_val : 16'hzzzz;

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0]  m_pend, m_isv, m_mask;
   bit          m_req;
   logic [15:0] m_ret[$];
   int          m_src[$];
   // sampled irq_in at the last three clock edges, newest first
   logic [7:0]  smp0, smp1, smp2;

   function automatic int m_cand();
      for (int i = 0; i < 8; i++)
         if (m_pend[i] && m_mask[i]) return i;
      return -1;
   endfunction

   function automatic bit m_blocked(input int c);
      if (m_ret.size() >= DEPTH) return 1'b1;
      if (!NEST) return m_isv != 8'h00;
      for (int j = 0; j <= c; j++)
         if (m_isv[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] m_bus();
      if (bus_if.io_push_retaddr)
         return (m_ret.size() > 0) ? m_ret[$] : 16'h0000;
      if (bus_if.io_push_int_addr)
         return (m_src.size() > 0) ? 16'hFF00 + 16'(m_src[$] * 4) : 16'h0000;
      if (bus_if.io_push_ints)
         return {m_isv, m_pend};
      return {8'h00, m_mask};
   endfunction

   task automatic model_step();
      int c;
      bit ok, ack, pop;
      logic [7:0] newp, clr;
      c    = m_cand();
      ok   = (c >= 0) && !m_blocked(c);
      ack  = bus_if.io_store_retaddr && m_req && (c >= 0);
      pop  = bus_if.io_push_retaddr && (m_ret.size() > 0);
      // a line seen high two edges ago after being low three edges ago
      newp = smp1 & ~smp2;
      clr  = ack ? 8'(1 << c) : 8'h00;
      if (ack) begin
         m_ret.push_back(tb_drv_val);
         m_src.push_back(c);
         m_isv[c] = 1'b1;
      end else if (pop) begin
         m_isv[m_src[$]] = 1'b0;
         void'(m_ret.pop_back());
         void'(m_src.pop_back());
      end
      m_pend = (m_pend & ~clr) | newp;
      if (bus_if.io_write && bus_if.d_addr == MADDR)
         m_mask = tb_drv_val[7:0];
      m_req = m_req ? !ack : ok;
      smp2 = smp1;
      smp1 = smp0;
      smp0 = bus_if.irq_in;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = 8'h00;
         m_isv  = 8'h00;
         m_mask = 8'h00;
         m_req  = 1'b0;
         smp0   = 8'h00;
         smp1   = 8'h00;
         smp2   = 8'h00;
         m_ret.delete();
         m_src.delete();
      end else begin
         model_step();
      end
   end

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against model every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("io_interrupt", {15'd0, bus_if.io_interrupt}, {15'd0, m_req});
         if (bus_if.io_push_retaddr || bus_if.io_push_int_addr ||
             bus_if.io_push_ints ||
             (bus_if.io_read && bus_if.d_addr == MADDR))
            chk("d_bus", d_bus, m_bus());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_strobes();
      bus_if.io_store_retaddr = 1'b0;
      bus_if.io_push_retaddr  = 1'b0;
      bus_if.io_push_ints     = 1'b0;
      bus_if.io_push_int_addr = 1'b0;
      bus_if.io_read          = 1'b0;
      bus_if.io_write         = 1'b0;
      bus_if.d_addr           = 16'h0000;
      tb_drv_en               = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      clear_strobes();
   endtask

   task automatic write_mask(input logic [7:0] v);
      bus_if.io_write = 1'b1;
      bus_if.d_addr   = MADDR;
      tb_drv_en       = 1'b1;
      tb_drv_val      = {8'h00, v};
      step();
   endtask

   task automatic store(input logic [15:0] v);
      bus_if.io_store_retaddr = 1'b1;
      tb_drv_en               = 1'b1;
      tb_drv_val              = v;
      step();
   endtask

   task automatic push_ret(input string n, input logic [15:0] exp);
      bus_if.io_push_retaddr = 1'b1;
      #1 chk(n, d_bus, exp);
      step();
   endtask

   task automatic push_vec(input string n, input logic [15:0] exp);
      bus_if.io_push_int_addr = 1'b1;
      #1 chk(n, d_bus, exp);
      step();
   endtask

   task automatic push_ints(input string n, input logic [15:0] exp);
      bus_if.io_push_ints = 1'b1;
      #1 chk(n, d_bus, exp);
      step();
   endtask

   task automatic wait_req(input string n);
      int k = 0;
      while (!bus_if.io_interrupt && k < 20) begin
         step();
         k++;
      end
      chk(n, {15'd0, bus_if.io_interrupt}, 16'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bus_if.irq_in = 8'h00;
      clear_strobes();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // reset state
      #1 chk("rst_irq", {15'd0, bus_if.io_interrupt}, 16'd0);
      push_ints("rst_ints", 16'h0000);
      bus_if.io_read = 1'b1;
      bus_if.d_addr  = MADDR;
      #1 chk("rst_mask", d_bus, 16'h0000);
      step();

      // masked edge on 3 latches pending, no request
      bus_if.irq_in = 8'h08;
      repeat (5) step();
      push_ints("pend3", 16'h0008);
      chk("masked_irq", {15'd0, bus_if.io_interrupt}, 16'd0);
      write_mask(8'h08);
      #1 chk("irq_lat0", {15'd0, bus_if.io_interrupt}, 16'd0);
      step();
      #1 chk("irq_lat1", {15'd0, bus_if.io_interrupt}, 16'd1);
      store(16'h1234);
      #1 chk("irq_fall", {15'd0, bus_if.io_interrupt}, 16'd0);
      push_vec("vec3", 16'hFF0C);
      push_ints("isv3", 16'h0800);
      push_ret("ret1234", 16'h1234);
      push_ints("isv_clr", 16'h0000);
      bus_if.irq_in = 8'h00;

      // simultaneous 2 and 5
      write_mask(8'h24);
      bus_if.irq_in = 8'h24;
      wait_req("req25a");
      store(16'h0100);
      push_vec("vec2", 16'hFF08);
      push_ret("ret2", 16'h0100);
      wait_req("req25b");
      store(16'h0200);
      push_vec("vec5", 16'hFF14);
      push_ret("ret5", 16'h0200);
      bus_if.irq_in = 8'h00;

      // source 4 in service, then source 1
      write_mask(8'h12);
      bus_if.irq_in = 8'h10;
      wait_req("req4");
      store(16'h0400);
      bus_if.irq_in = 8'h12;
      if (NEST) begin
         wait_req("req1_pre");
         store(16'h0100);
         push_ints("nest_ints", 16'h1200);
         push_vec("vec1", 16'hFF04);
         push_ret("ret1", 16'h0100);
         push_vec("vec4", 16'hFF10);
         push_ret("ret4", 16'h0400);
      end else begin
         repeat (8) step();
         #1 chk("no_pre", {15'd0, bus_if.io_interrupt}, 16'd0);
         push_ints("flat_ints", 16'h1002);
         push_ret("ret4", 16'h0400);
         wait_req("req1_post");
         store(16'h0101);
         push_vec("vec1", 16'hFF04);
         push_ret("ret1", 16'h0101);
      end
      bus_if.irq_in = 8'h00;

      // reset mid-service
      write_mask(8'h40);
      bus_if.irq_in = 8'h40;
      wait_req("req6");
      bus_if.irq_in = 8'h00;
      store(16'h6666);
      repeat (2) step();
      rst_n = 1'b0;
      #1 chk("arst_irq", {15'd0, bus_if.io_interrupt}, 16'd0);
      bus_if.io_push_ints = 1'b1;
      #1 chk("arst_ints", d_bus, 16'h0000);
      step();
      step();
      rst_n = 1'b1;
      push_ret("arst_ret", 16'h0000);
      push_ints("arst_ints2", 16'h0000);

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         if (cyc % 500 == 499) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end
         for (int b = 0; b < 8; b++)
            if ($urandom_range(15) == 0)
               bus_if.irq_in[b] = ~bus_if.irq_in[b];
         r = int'($urandom_range(99));
         if (m_req && r < 40) begin
            store(16'($urandom));
         end else if (r < 50) begin
            store(16'($urandom));
         end else if (r < 62) begin
            bus_if.io_push_retaddr = 1'b1;
            step();
         end else if (r < 72 && m_src.size() > 0) begin
            bus_if.io_push_int_addr = 1'b1;
            step();
         end else if (r < 80) begin
            bus_if.io_push_ints = 1'b1;
            step();
         end else if (r < 85) begin
            bus_if.io_read = 1'b1;
            bus_if.d_addr  = ($urandom_range(1) == 0) ? MADDR : 16'($urandom);
            step();
         end else if (r < 90) begin
            write_mask(m_mask | 8'($urandom));
         end else begin
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
